vga_timing_gen: RTL and testbench

Parametrised VGA/SVGA raster timing generator. It replaces the fixed 640x480 sync block in the display path of the Mandelbrot renderer. Every timing field, the pixel-clock divide ratio and the sync polarities are parameters. It adds a run/hold enable and line/frame start strobes. All outputs are registered and aligned to the current pixel_x/pixel_y, so downstream pixel logic sees zero sync-to-coordinate skew.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA/SVGA raster timing generator for the Mandelbrot display
// path. A divider turns the system clock into a pixel-rate strobe (p_tick).
// Each p_tick advances the pixel_x/pixel_y raster counters. Sync, blanking
// and start strobes are registered from the next-state counter values, so
// they always describe the coordinate currently on pixel_x/pixel_y.
//
// Line and frame order: visible, front porch, sync, back porch.
//
// Ports:
//   CLK_100MHz   in   system clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   en           in   run enable; low freezes divider, counters and levels
//   p_tick       out  pixel-rate strobe, one system clock wide
//   pixel_x      out  horizontal count 0..H_TOTAL-1
//   pixel_y      out  vertical count 0..V_TOTAL-1
//   hsync        out  horizontal sync, active level H_POL
//   vsync        out  vertical sync, active level V_POL
//   video_on     out  high inside the visible area
//   line_start   out  one-clock pulse after pixel_x is loaded with 0
//   frame_start  out  one-clock pulse after (pixel_x, pixel_y) is loaded with (0, 0)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CNT_W   = 10,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int CLK_DIV = 4,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0
) (
    input  logic             CLK_100MHz,
    input  logic             reset_n,
    input  logic             en,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;

    // reset_n is folded in so the strobe stays low while held in reset,
    // which matters when CLK_DIV=1 (div_cnt is then always at its max).
    assign p_tick = reset_n & en & (div_cnt == DIV_MAX);

    // Next raster position; only moves on a pixel tick.
    always_comb begin
        x_nxt = pixel_x;
        y_nxt = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_MAX) begin
                x_nxt = '0;
                y_nxt = (pixel_y == V_MAX) ? '0 : pixel_y + CNT_W'(1);
            end else begin
                x_nxt = pixel_x + CNT_W'(1);
            end
        end
    end

    // Reset parks the raster on the last pixel of the last line, so the
    // first tick after release wraps to (0, 0) and starts a full frame.
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            pixel_x     <= H_MAX;
            pixel_y     <= V_MAX;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            div_cnt     <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            hsync       <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? H_POL : ~H_POL;
            vsync       <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? V_POL : ~V_POL;
            video_on    <= (x_nxt < H_VIS_C) && (y_nxt < V_VIS_C);
            line_start  <= p_tick && (x_nxt == '0);
            frame_start <= p_tick && (x_nxt == '0) && (y_nxt == '0);
        end else begin
            // Held: levels and counters freeze, strobes drop.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share clock, reset and enable:
//   A: default 640x480 timing, CLK_DIV=4
//   B: tiny raster 15x8, CLK_DIV=4, active-low syncs
//   C: tiny raster 16x9 (H_TOTAL = 2^CNT_W), CLK_DIV=1, active-high syncs
// Expected outputs come from an arithmetic model driven by the number of
// enabled clocks since reset; they are pushed at each rising edge and
// popped/compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int div;
        int hvis, hfp, hsync, hbp;
        int vvis, vfp, vsync, vbp;
        bit hpol, vpol;
    } cfg_t;

    logic clk;
    logic rst_n;
    logic en;

    logic       a_pt, a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_hs, b_vs, b_von, b_ls, b_fs;
    logic [3:0] b_x, b_y;
    logic       c_pt, c_hs, c_vs, c_von, c_ls, c_fs;
    logic [3:0] c_x, c_y;

    logic [29:0] obs_a, obs_b, obs_c;
    logic [29:0] exp_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   run      = 0;
    bit   adv      = 0;
    cfg_t cfg_a, cfg_b, cfg_c;

    vga_timing_gen dut_a (
        .CLK_100MHz(clk), .reset_n(rst_n), .en(en), .p_tick(a_pt),
        .pixel_x(a_x), .pixel_y(a_y), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CNT_W(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(4),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut_b (
        .CLK_100MHz(clk), .reset_n(rst_n), .en(en), .p_tick(b_pt),
        .pixel_x(b_x), .pixel_y(b_y), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .CNT_W(4), .H_VIS(10), .H_FP(1), .H_SYNC(3), .H_BP(2),
        .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_c (
        .CLK_100MHz(clk), .reset_n(rst_n), .en(en), .p_tick(c_pt),
        .pixel_x(c_x), .pixel_y(c_y), .hsync(c_hs), .vsync(c_vs),
        .video_on(c_von), .line_start(c_ls), .frame_start(c_fs)
    );

    assign obs_a = {a_pt, 2'b0, a_x, 2'b0, a_y, a_hs, a_vs, a_von, a_ls, a_fs};
    assign obs_b = {b_pt, 8'b0, b_x, 8'b0, b_y, b_hs, b_vs, b_von, b_ls, b_fs};
    assign obs_c = {c_pt, 8'b0, c_x, 8'b0, c_y, c_hs, c_vs, c_von, c_ls, c_fs};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Position is derived from the pixel-tick count t = run / div:
    // t=0 is the parked reset position, tick k lands on raster index k-1.
    function automatic logic [29:0] model(input cfg_t c, input int r, input bit a,
                                          input bit en_v, input bit rst_v);
        int ht, vt, t, x, y;
        bit pt, hs, vs, von, ls, fs;
        ht = c.hvis + c.hfp + c.hsync + c.hbp;
        vt = c.vvis + c.vfp + c.vsync + c.vbp;
        t  = r / c.div;
        if (t == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            x = (t - 1) % ht;
            y = ((t - 1) / ht) % vt;
        end
        pt  = rst_v && en_v && (r % c.div == c.div - 1);
        hs  = (x >= c.hvis + c.hfp && x < c.hvis + c.hfp + c.hsync) ? c.hpol : !c.hpol;
        vs  = (y >= c.vvis + c.vfp && y < c.vvis + c.vfp + c.vsync) ? c.vpol : !c.vpol;
        von = (x < c.hvis) && (y < c.vvis);
        ls  = a && (r % c.div == 0) && (x == 0);
        fs  = ls && (y == 0);
        return {pt, 12'(x), 12'(y), hs, vs, von, ls, fs};
    endfunction

    // ---------------- checkers ----------------
    task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model at the rising edge and queue the expected
    // outputs, then pop and compare them on the falling edge.
    task automatic tick();
        logic [29:0] e;
        @(posedge clk);
        if (!rst_n) begin
            run = 0;
            adv = 0;
        end else if (en) begin
            run++;
            adv = 1;
        end else begin
            adv = 0;
        end
        exp_q.push_back(model(cfg_a, run, adv, en, rst_n));
        exp_q.push_back(model(cfg_b, run, adv, en, rst_n));
        exp_q.push_back(model(cfg_c, run, adv, en, rst_n));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL queue_empty obs=0 exp=%0d", 3 - k);
            end else begin
                e = exp_q.pop_front();
                case (k)
                    0:       check("A_raster", obs_a, e);
                    1:       check("B_raster", obs_b, e);
                    default: check("C_raster", obs_c, e);
                endcase
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        bit found;
        int a_hs_min, a_hs_max, a_von_off_min, a_von_on_max;
        int a_ls_last, a_ls_per, b_fs_last, b_fs_per, c_fs_last, c_fs_per;
        int b_vs_min, b_vs_max, c_vs_min, c_vs_max, c_hs_min, c_hs_max;
        int b_max_x, b_max_y, c_max_x, c_max_y, c_pt_low, cyc;

        cfg_a = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        cfg_b = '{4, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0};
        cfg_c = '{1, 10, 1, 3, 2, 5, 1, 2, 1, 1'b1, 1'b1};

        // Reset held with en high: reset values, no p_tick even at CLK_DIV=1.
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        check_int("reset_a_x", int'(a_x), 799);
        check_int("reset_a_y", int'(a_y), 524);
        check_int("reset_c_ptick", int'(c_pt), 0);

        // Release: p_tick first seen after 3 rising edges (during the 4th clock).
        rst_n = 1'b1;
        k = 0;
        found = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (a_pt) begin
                k = i;
                found = 1;
                break;
            end
        end
        check_int("first_ptick_edges", k, 3);
        tick();
        check_int("start_a_x", int'(a_x), 0);
        check_int("start_a_y", int'(a_y), 0);
        check_int("start_a_fs_ls", int'({a_fs, a_ls}), 3);
        check_int("start_a_von_hs_vs", int'({a_von, a_hs, a_vs}), 7);

        // Hold for 37 clocks at pixel_x=100 on instance A.
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (a_x == 10'd100) begin
                found = 1;
                break;
            end
            tick();
        end
        check_int("reach_x100", int'(found), 1);
        en = 1'b0;
        repeat (37) tick();
        check_int("hold_a_x", int'(a_x), 100);
        check_int("hold_a_ptick", int'(a_pt), 0);
        en = 1'b1;

        // Free run: collect boundary statistics.
        a_hs_min = 99999; a_hs_max = -1; a_von_off_min = 99999; a_von_on_max = -1;
        a_ls_last = -1; a_ls_per = 0; b_fs_last = -1; b_fs_per = 0;
        c_fs_last = -1; c_fs_per = 0;
        b_vs_min = 99; b_vs_max = -1; c_vs_min = 99; c_vs_max = -1;
        c_hs_min = 99; c_hs_max = -1;
        b_max_x = 0; b_max_y = 0; c_max_x = 0; c_max_y = 0; c_pt_low = 0;
        cyc = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            cyc++;
            if (!a_hs) begin
                if (int'(a_x) < a_hs_min) a_hs_min = int'(a_x);
                if (int'(a_x) > a_hs_max) a_hs_max = int'(a_x);
            end
            if (!a_von && a_y < 10'd480 && int'(a_x) < a_von_off_min) a_von_off_min = int'(a_x);
            if (a_von && int'(a_x) > a_von_on_max) a_von_on_max = int'(a_x);
            if (a_ls) begin
                if (a_ls_last >= 0) a_ls_per = cyc - a_ls_last;
                a_ls_last = cyc;
            end
            if (b_fs) begin
                if (b_fs_last >= 0) b_fs_per = cyc - b_fs_last;
                b_fs_last = cyc;
            end
            if (c_fs) begin
                if (c_fs_last >= 0) c_fs_per = cyc - c_fs_last;
                c_fs_last = cyc;
            end
            if (!b_vs) begin
                if (int'(b_y) < b_vs_min) b_vs_min = int'(b_y);
                if (int'(b_y) > b_vs_max) b_vs_max = int'(b_y);
            end
            if (c_vs) begin
                if (int'(c_y) < c_vs_min) c_vs_min = int'(c_y);
                if (int'(c_y) > c_vs_max) c_vs_max = int'(c_y);
            end
            if (c_hs) begin
                if (int'(c_x) < c_hs_min) c_hs_min = int'(c_x);
                if (int'(c_x) > c_hs_max) c_hs_max = int'(c_x);
            end
            if (int'(b_x) > b_max_x) b_max_x = int'(b_x);
            if (int'(b_y) > b_max_y) b_max_y = int'(b_y);
            if (int'(c_x) > c_max_x) c_max_x = int'(c_x);
            if (int'(c_y) > c_max_y) c_max_y = int'(c_y);
            if (!c_pt) c_pt_low++;
        end
        check_int("a_hsync_low_first", a_hs_min, 656);
        check_int("a_hsync_low_last", a_hs_max, 751);
        check_int("a_video_off_first_x", a_von_off_min, 640);
        check_int("a_video_on_last_x", a_von_on_max, 639);
        check_int("a_line_period", a_ls_per, 3200);
        check_int("b_frame_period", b_fs_per, 480);
        check_int("c_frame_period", c_fs_per, 144);
        check_int("b_vsync_low_first", b_vs_min, 5);
        check_int("b_vsync_low_last", b_vs_max, 6);
        check_int("c_vsync_high_first", c_vs_min, 6);
        check_int("c_vsync_high_last", c_vs_max, 7);
        check_int("c_hsync_high_first", c_hs_min, 11);
        check_int("c_hsync_high_last", c_hs_max, 13);
        check_int("b_max_x", b_max_x, 14);
        check_int("b_max_y", b_max_y, 7);
        check_int("c_max_x", c_max_x, 15);
        check_int("c_max_y", c_max_y, 8);
        check_int("c_ptick_low_cycles", c_pt_low, 0);

        // Mid-frame asynchronous reset, pulsed between clock edges.
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (b_x == 4'd5 && b_y == 4'd2) begin
                found = 1;
                break;
            end
            tick();
        end
        check_int("reach_b_5_2", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("async_a_x", int'(a_x), 799);
        check_int("async_a_y", int'(a_y), 524);
        check_int("async_a_levels", int'({a_pt, a_hs, a_vs, a_von, a_ls, a_fs}), 6'b011000);
        check_int("async_b_xy", int'({b_x, b_y}), 8'hE7);
        check_int("async_b_von", int'(b_von), 0);
        check_int("async_c_levels", int'({c_pt, c_hs, c_vs, c_von, c_ls, c_fs}), 0);
        check_int("async_c_xy", int'({c_x, c_y}), 8'hF8);
        tick();
        rst_n = 1'b1;

        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (b_fs) begin
                found = 1;
                break;
            end
        end
        check_int("restart_b_fs_seen", int'(found), 1);
        check_int("restart_b_xy", int'({b_x, b_y}), 0);
        check_int("restart_a_fs", int'(a_fs), 1);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
